// File: rtl/tissue_ctrl.sv
// tissue_ctrl: sequences clear, serial per-cell config load and stepping of the CA tissue.
// Optional feature: define TISSUE_CTRL_PAUSE_EN to let `pause` freeze stepping.
module tissue_ctrl #(
    parameter int unsigned NUM_CELLS      = 270,
    parameter int unsigned RANDOMIZED_LEN = 2,
    parameter int unsigned NUM_STATUS     = 8,
    parameter int unsigned STEP_W         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [STEP_W-1:0]                 steps,
    input  logic [2**(NUM_STATUS+1)-1:0]      cfg_table,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_status,
    input  logic [RANDOMIZED_LEN*8-1:0]       cfg_chance,
    input  logic [RANDOMIZED_LEN*8-1:0]       cfg_seed,
    input  logic                              pause,
    input  logic                              abort,
    output logic                              tis_rst,
    output logic                              tis_init,
    output logic                              tis_status,
    output logic [RANDOMIZED_LEN*8-1:0]       tis_chance,
    output logic [RANDOMIZED_LEN*8-1:0]       tis_seed,
    output logic [2**(NUM_STATUS+1)-1:0]      tis_table,
    output logic                              tis_run,
    output logic [STEP_W-1:0]                 step_cnt,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned TW = 2**(NUM_STATUS+1);
    localparam int unsigned CW = $clog2(NUM_CELLS + 1);
    localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [TW-1:0]     table_q, table_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [CW-1:0]     load_cnt_q, load_cnt_d;
    logic              run_gate;
    logic              accept_start;

`ifdef TISSUE_CTRL_PAUSE_EN
    assign run_gate = !pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign run_gate     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            steps_q    <= '0;
            table_q    <= '0;
            step_cnt_q <= '0;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            table_q    <= table_d;
            step_cnt_q <= step_cnt_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        table_d      = table_q;
        step_cnt_d   = step_cnt_q;
        load_cnt_d   = load_cnt_q;
        accept_start = start && (state_q == IDLE || state_q == DONE);

        // abort suppresses the handshake and the step strobe in its own cycle
        cfg_ready = (state_q == LOAD) && !abort;
        tis_init  = cfg_ready && cfg_valid;
        tis_run   = (state_q == RUN) && !abort && run_gate;
        tis_rst   = !rst || (state_q == CLEAR);
        busy      = (state_q == CLEAR) || (state_q == LOAD) || (state_q == RUN);
        done      = (state_q == DONE);

        if (abort) begin
            state_d = IDLE;
        end else if (accept_start) begin
            state_d    = CLEAR;
            steps_d    = steps;
            table_d    = cfg_table;
            step_cnt_d = '0;
            load_cnt_d = '0;
        end else begin
            unique case (state_q)
                CLEAR: state_d = LOAD;
                LOAD: begin
                    if (tis_init) begin
                        load_cnt_d = load_cnt_q + CW'(1);
                        if (load_cnt_q == LAST_CELL)
                            state_d = (steps_q != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (step_cnt_q == steps_q) begin
                        state_d = DONE;
                    end else if (tis_run) begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                        if (step_cnt_q + STEP_W'(1) == steps_q)
                            state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tis_status = cfg_status;
    assign tis_chance = cfg_chance;
    assign tis_seed   = cfg_seed;
    assign tis_table  = table_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_tissue_ctrl.sv
// Scoreboard bench for tissue_ctrl: stimulus pushes expected run results, a negedge monitor checks them.
module tb_tissue_ctrl;

    localparam int unsigned NC = 4;
`ifdef TISSUE_CTRL_PAUSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, cfg_valid, cfg_ready, cfg_status, pause, abort;
    logic [15:0] steps, step_cnt;
    logic [7:0]  cfg_table, tis_table, cfg_chance, cfg_seed, tis_chance, tis_seed;
    logic        tis_rst, tis_init, tis_status, tis_run, busy, done;

    tissue_ctrl #(.NUM_CELLS(NC), .RANDOMIZED_LEN(1), .NUM_STATUS(2), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .steps(steps), .cfg_table(cfg_table),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_status(cfg_status),
        .cfg_chance(cfg_chance), .cfg_seed(cfg_seed), .pause(pause), .abort(abort),
        .tis_rst(tis_rst), .tis_init(tis_init), .tis_status(tis_status),
        .tis_chance(tis_chance), .tis_seed(tis_seed), .tis_table(tis_table),
        .tis_run(tis_run), .step_cnt(step_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] exp_cyc;
        logic [15:0] steps;
        logic [7:0]  tbl;
        logic [67:0] cells;
    } rec_t;

    rec_t        sb[$];
    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: rebuilds the tissue's init chain from observed shifts and checks each completed run
    logic [67:0] chain = '0;
    int unsigned runs = 0;
    logic        done_prev = 1'b0;
    always @(negedge clk) begin
        rec_t r;
        if (rst) begin
            if (tis_rst) begin
                chain = '0;
                runs  = 0;
            end
            if (tis_init) chain = {chain[50:0], tis_status, tis_chance, tis_seed};
            if (tis_run) runs++;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = sb.pop_front();
                    chk("done_cycle", cyc, r.exp_cyc);
                    chk("done_step_cnt", step_cnt, r.steps);
                    chk("run_cycles", runs, r.steps);
                    chk("table", tis_table, r.tbl);
                    chk("chain_cells", chain, r.cells);
                end
            end
        end
        done_prev = done;
    end

    task automatic do_run(input logic [15:0] nsteps, input int unsigned vpct,
                          input logic [31:0] pmask, input bit poke_start);
        logic [16:0] w [NC];
        logic [67:0] cells;
        logic [7:0]  tbl;
        int unsigned c0, nl, nr, idx, k;
        bit          v, p;
        rec_t        r;
        cells = '0;
        tbl   = 8'($urandom);
        for (int i = 0; i < NC; i++) begin
            w[i] = 17'($urandom);
            cells[(NC-1-i)*17 +: 17] = w[i];
        end
        steps = nsteps; cfg_table = tbl; start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        chk("clear_tis_rst", tis_rst, 1);
        chk("clear_busy", busy, 1);
        chk("clear_ready", cfg_ready, 0);
        tick();
        nl = 0; idx = 0;
        while (idx < NC) begin
            v = ($urandom_range(99) < vpct);
            cfg_valid = v;
            {cfg_status, cfg_chance, cfg_seed} = v ? w[idx] : 17'($urandom);
            #1;
            chk("load_ready", cfg_ready, 1);
            chk("load_init", tis_init, v);
            tick();
            nl++;
            if (v) idx++;
        end
        cfg_valid = 1'b0;
        nr = 0; k = 0;
        while (k < nsteps) begin
            p = (nr < 32) && pmask[nr];
            pause = p;
            start = poke_start && (nr == 0);
            tick();
            nr++;
            if (!p || !PEN) k++;
        end
        pause = 1'b0; start = 1'b0;
        r = '{exp_cyc: c0 + 1 + nl + nr, steps: nsteps, tbl: tbl, cells: cells};
        sb.push_back(r);
        chk("done_at_end", done, 1);
        chk("busy_at_end", busy, 0);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; steps = '0; cfg_table = '0; cfg_valid = 1'b0;
        cfg_status = 1'b0; cfg_chance = '0; cfg_seed = '0; pause = 1'b0; abort = 1'b0;
        repeat (3) tick();
        chk("rst_tis_rst", tis_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_outs", {cfg_ready, tis_init, tis_run, tis_table}, 0);
        rst = 1'b1;
        tick();
        chk("idle_tis_rst", tis_rst, 0);

        do_run(16'd5, 100, 32'd0, 1'b0);
        do_run(16'd4, 50, 32'd0, 1'b0);
        do_run(16'd0, 100, 32'd0, 1'b0);
        do_run(16'd5, 100, 32'b11100, 1'b0);

        // Abort in RUN at step 2, then abort colliding with a handshake in LOAD
        steps = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cfg_valid = 1'b1;
        repeat (NC) tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("pre_abort_cnt", step_cnt, 2);
        abort = 1'b1;
        #1;
        chk("abort_no_run", tis_run, 0);
        tick();
        abort = 1'b0;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", step_cnt, 2);
        tick();
        tick();
        chk("abort_cnt_held", step_cnt, 2);
        steps = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_cnt", step_cnt, 0);
        tick();
        cfg_valid = 1'b1; abort = 1'b1;
        #1;
        chk("abort_hs_init", tis_init, 0);
        chk("abort_hs_ready", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0; abort = 1'b0;
        chk("abort_hs_busy", busy, 0);

        // Reset mid-RUN
        steps = 16'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cfg_valid = 1'b1;
        repeat (NC) tick();
        cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_tis_rst", tis_rst, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_state", {busy, done, step_cnt}, 0);
        tick();

        for (int n = 0; n < 8; n++)
            do_run(16'($urandom_range(12)), $urandom_range(100, 30), $urandom, 1'b1);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
